// File: rtl/monster_spawner_pkg.sv
// Shared constants and types for the monster spawner: slot count, slot-state
// encoding and the jitter LFSR constants.
package monster_spawner_pkg;

    localparam int NUM_SLOTS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIVE = 2'd1,
        WAIT  = 2'd2
    } slot_state_t;

    // Fibonacci LFSR, taps 8,6,5,4 expressed as a mask over lfsr[7:0]
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

endpackage

// File: rtl/spawn_slot.sv
// One monster slot: death-edge detect on monster_dead, IDLE/ALIVE/WAIT state
// and the respawn down-counter.
//
//   state | meaning
//   IDLE  | never spawned this wave; eligible immediately
//   ALIVE | monster running; a death rise starts the respawn timer
//   WAIT  | counting down; eligible once the timer reaches 0
module spawn_slot
    import monster_spawner_pkg::*;
#(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          monster_dead,
    input  logic          grant,
    input  logic [TW-1:0] load_value,
    output logic          eligible,
    output logic          alive
);

    slot_state_t   state;
    logic [TW-1:0] timer;
    logic          prev;
    logic          rise;

    assign rise     = monster_dead & ~prev;
    assign alive    = (state == ALIVE);
    assign eligible = (state == IDLE) || ((state == WAIT) && (timer == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            timer <= '0;
            prev  <= 1'b1;
        end else begin
            prev <= monster_dead;
            case (state)
                IDLE: begin
                    if (grant) state <= ALIVE;
                end
                ALIVE: begin
                    if (rise) begin
                        state <= WAIT;
                        timer <= load_value;
                    end
                end
                WAIT: begin
                    if (grant) begin
                        state <= ALIVE;
                    end else if (enable && (timer != '0)) begin
                        timer <= timer - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/monster_spawner.sv
// Monster spawner top: four slots, round-robin grant, wave quota and wave_done.
// Optional respawn jitter from an 8-bit LFSR when SPAWN_JITTER_EN is defined.
module monster_spawner
    import monster_spawner_pkg::*;
#(
    parameter int RESPAWN_CYCLES = 100_000_000,
    parameter int WAVE_SIZE      = 12,
    parameter int JITTER_BITS    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [NUM_SLOTS-1:0] monster_dead,
    output logic [NUM_SLOTS-1:0] spawn,
    output logic [NUM_SLOTS-1:0] slot_alive,
    output logic [3:0]           spawned_total,
    output logic                 wave_done
);

    localparam int PW   = $clog2(NUM_SLOTS);
    // Width covers the jitter range in both builds so it does not depend on the macro
    localparam int TMAX = RESPAWN_CYCLES - 1 + (1 << JITTER_BITS) - 1;
    localparam int TW   = (TMAX < 1) ? 1 : $clog2(TMAX + 1);
    localparam logic [3:0] QUOTA = 4'(WAVE_SIZE);

    logic [NUM_SLOTS-1:0] eligible;
    logic [NUM_SLOTS-1:0] grant;
    logic [PW-1:0]        ptr;
    logic [PW-1:0]        grant_idx;
    logic                 found;
    logic [TW-1:0]        load_value;

`ifdef SPAWN_JITTER_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr <= LFSR_SEED;
        else     lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
    end

    assign load_value = TW'(RESPAWN_CYCLES - 1) + TW'(lfsr[JITTER_BITS-1:0]);
`else
    assign load_value = TW'(RESPAWN_CYCLES - 1);
`endif

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        spawn_slot #(.TW(TW)) u_slot (
            .clk          (clk),
            .rst          (rst),
            .enable       (enable),
            .monster_dead (monster_dead[i]),
            .grant        (grant[i]),
            .load_value   (load_value),
            .eligible     (eligible[i]),
            .alive        (slot_alive[i])
        );
    end

    // Round-robin search from ptr upward; PW-bit index wraps 3 -> 0 on its own
    always_comb begin
        logic [PW-1:0] idx;
        idx       = '0;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        if (enable && (spawned_total < QUOTA)) begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                idx = ptr + PW'(k);
                if (!found && eligible[idx]) begin
                    found     = 1'b1;
                    grant_idx = idx;
                end
            end
        end
        if (found) grant[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spawn         <= '0;
            ptr           <= '0;
            spawned_total <= '0;
            wave_done     <= 1'b0;
        end else begin
            spawn <= grant;
            if (found) begin
                spawned_total <= spawned_total + 4'd1;
                ptr           <= grant_idx + 1'b1;
            end
            if ((spawned_total == QUOTA) && (slot_alive == '0)) wave_done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_monster_spawner.sv
// Self-checking bench for monster_spawner (RESPAWN_CYCLES=4, WAVE_SIZE=6):
// vector table, hand-written corner sequences and a random run against a model.
module tb_monster_spawner;

    localparam int R = 4;
    localparam int W = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] monster_dead = 4'b0000;
    logic [3:0] spawn;
    logic [3:0] slot_alive;
    logic [3:0] spawned_total;
    logic       wave_done;

    int n_checks = 0;
    int n_fail   = 0;

    monster_spawner #(.RESPAWN_CYCLES(R), .WAVE_SIZE(W), .JITTER_BITS(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .monster_dead  (monster_dead),
        .spawn         (spawn),
        .slot_alive    (slot_alive),
        .spawned_total (spawned_total),
        .wave_done     (wave_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic tick(input bit en, input logic [3:0] dead);
        enable       = en;
        monster_dead = dead;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] dead);
        rst          = 1'b1;
        enable       = 1'b0;
        monster_dead = dead;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Behavioural model: a waiting slot becomes eligible once R-1 enabled
    // edges have elapsed after its death edge.
    int         m_state[4];   // 0 idle, 1 alive, 2 waiting
    int         m_mark[4];
    int         m_ptr, m_total, en_count;
    logic [3:0] m_prev, m_spawn;
    bit         m_done;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_state[i] = 0;
            m_mark[i]  = 0;
        end
        m_ptr = 0; m_total = 0; en_count = 0;
        m_prev = 4'b1111; m_spawn = 4'b0000; m_done = 1'b0;
    endfunction

    function automatic logic [3:0] model_alive();
        logic [3:0] a;
        a = 4'b0000;
        for (int i = 0; i < 4; i++) if (m_state[i] == 1) a[i] = 1'b1;
        return a;
    endfunction

    function automatic void model_step(input bit en, input logic [3:0] dead);
        logic [3:0] rise;
        int g;
        int s;
        rise = dead & ~m_prev;
        g = -1;
        if (en && m_total < W) begin
            for (int k = 0; k < 4; k++) begin
                s = (m_ptr + k) % 4;
                if (g < 0 && (m_state[s] == 0 || (m_state[s] == 2 && en_count - m_mark[s] >= R - 1)))
                    g = s;
            end
        end
        if (m_total == W && model_alive() == 4'b0000) m_done = 1'b1;
        if (en) en_count++;
        for (int i = 0; i < 4; i++) begin
            if (m_state[i] == 1 && rise[i]) begin
                m_state[i] = 2;
                m_mark[i]  = en_count;
            end
        end
        m_spawn = 4'b0000;
        if (g >= 0) begin
            m_spawn[g] = 1'b1;
            m_state[g] = 1;
            m_total++;
            m_ptr = (g + 1) % 4;
        end
        m_prev = dead;
    endfunction

    typedef struct {
        bit         en;
        logic [3:0] dead;
        logic [3:0] sp;
        logic [3:0] al;
        logic [3:0] tot;
        bit         done;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mkv(input bit en, input logic [3:0] dead, input logic [3:0] sp,
                                 input logic [3:0] al, input logic [3:0] tot, input bit done);
        vec_t v;
        v.en = en; v.dead = dead; v.sp = sp; v.al = al; v.tot = tot; v.done = done;
        return v;
    endfunction

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        do_reset(4'b0000);
        check("reset_spawn", int'(spawn), 0);
        check("reset_alive", int'(slot_alive), 0);
        check("reset_total", int'(spawned_total), 0);
        check("reset_done",  int'(wave_done), 0);

`ifndef SPAWN_JITTER_EN
        // Initial fill, single respawn, simultaneous deaths at ptr=3, quota, wave_done
        vecs[0]  = mkv(1, 4'b0000, 4'b0001, 4'b0001, 4'd1, 0);
        vecs[1]  = mkv(1, 4'b0000, 4'b0010, 4'b0011, 4'd2, 0);
        vecs[2]  = mkv(1, 4'b0000, 4'b0100, 4'b0111, 4'd3, 0);
        vecs[3]  = mkv(1, 4'b0000, 4'b1000, 4'b1111, 4'd4, 0);
        vecs[4]  = mkv(1, 4'b0000, 4'b0000, 4'b1111, 4'd4, 0);
        vecs[5]  = mkv(1, 4'b0100, 4'b0000, 4'b1011, 4'd4, 0);
        vecs[6]  = mkv(1, 4'b0100, 4'b0000, 4'b1011, 4'd4, 0);
        vecs[7]  = mkv(1, 4'b0100, 4'b0000, 4'b1011, 4'd4, 0);
        vecs[8]  = mkv(1, 4'b0100, 4'b0000, 4'b1011, 4'd4, 0);
        vecs[9]  = mkv(1, 4'b0100, 4'b0100, 4'b1111, 4'd5, 0);
        vecs[10] = mkv(1, 4'b0100, 4'b0000, 4'b1111, 4'd5, 0);
        vecs[11] = mkv(1, 4'b0000, 4'b0000, 4'b1111, 4'd5, 0);
        vecs[12] = mkv(1, 4'b0011, 4'b0000, 4'b1100, 4'd5, 0);
        vecs[13] = mkv(1, 4'b0011, 4'b0000, 4'b1100, 4'd5, 0);
        vecs[14] = mkv(1, 4'b0011, 4'b0000, 4'b1100, 4'd5, 0);
        vecs[15] = mkv(1, 4'b0011, 4'b0000, 4'b1100, 4'd5, 0);
        vecs[16] = mkv(1, 4'b0011, 4'b0001, 4'b1101, 4'd6, 0);
        vecs[17] = mkv(1, 4'b0011, 4'b0000, 4'b1101, 4'd6, 0);
        vecs[18] = mkv(1, 4'b0011, 4'b0000, 4'b1101, 4'd6, 0);
        vecs[19] = mkv(1, 4'b0010, 4'b0000, 4'b1101, 4'd6, 0);
        vecs[20] = mkv(1, 4'b1111, 4'b0000, 4'b0000, 4'd6, 0);
        vecs[21] = mkv(1, 4'b1111, 4'b0000, 4'b0000, 4'd6, 1);
        vecs[22] = mkv(1, 4'b1111, 4'b0000, 4'b0000, 4'd6, 1);

        for (int v = 0; v < 23; v++) begin
            tick(vecs[v].en, vecs[v].dead);
            check($sformatf("vec%0d_spawn", v), int'(spawn), int'(vecs[v].sp));
            check($sformatf("vec%0d_alive", v), int'(slot_alive), int'(vecs[v].al));
            check($sformatf("vec%0d_total", v), int'(spawned_total), int'(vecs[v].tot));
            check($sformatf("vec%0d_done", v), int'(wave_done), int'(vecs[v].done));
        end

        // enable low for 10 cycles during WAIT delays the respawn by 10
        begin
            int first;
            logic [3:0] first_sp;
            first = -1;
            first_sp = 4'b0000;
            do_reset(4'b0000);
            repeat (4) tick(1, 4'b0000);
            tick(1, 4'b0010);
            for (int c = 1; c <= 30; c++) begin
                tick(!(c >= 2 && c <= 11), 4'b0010);
                if (spawn != 4'b0000 && first < 0) begin
                    first = c;
                    first_sp = spawn;
                end
            end
            check("gap_delay", first, 14);
            check("gap_spawn", int'(first_sp), 4'b0010);
        end
`endif

        // Asynchronous reset mid-WAIT, with slot 0 already dead through reset
        do_reset(4'b0000);
        repeat (4) tick(1, 4'b0000);
        tick(1, 4'b1000);
        tick(1, 4'b1000);
        check("pre_rst_total", int'(spawned_total), 4);
        check("pre_rst_alive", int'(slot_alive), 4'b0111);
        #2;
        rst = 1'b1;
        #1;
        check("async_spawn", int'(spawn), 0);
        check("async_alive", int'(slot_alive), 0);
        check("async_total", int'(spawned_total), 0);
        check("async_done",  int'(wave_done), 0);
        monster_dead = 4'b0001;
        enable = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(1, 4'b0001);
        check("post_rst_first", int'(spawn), 4'b0001);
        repeat (3) tick(1, 4'b0001);
        repeat (3) tick(1, 4'b0001);
        check("no_false_edge_alive", int'(slot_alive), 4'b1111);
        check("no_false_edge_total", int'(spawned_total), 4);

`ifndef SPAWN_JITTER_EN
        // Random run against the behavioural model
        for (int run = 0; run < 6; run++) begin
            logic [3:0] dead;
            bit en;
            dead = 4'($urandom_range(0, 15));
            do_reset(dead);
            model_reset();
            for (int c = 0; c < 80; c++) begin
                en = ($urandom_range(0, 9) != 0);
                for (int i = 0; i < 4; i++)
                    if ($urandom_range(0, 5) == 0) dead[i] = ~dead[i];
                model_step(en, dead);
                tick(en, dead);
                check("rnd_spawn", int'(spawn), int'(m_spawn));
                check("rnd_alive", int'(slot_alive), int'(model_alive()));
                check("rnd_total", int'(spawned_total), m_total);
                check("rnd_done",  int'(wave_done), int'(m_done));
            end
        end
`else
        // Jittered respawn delays stay within R .. R+7 and vary
        begin
            int seen_min, seen_max, d;
            seen_min = 1000;
            seen_max = -1;
            for (int wv = 0; wv < 25; wv++) begin
                do_reset(4'b0000);
                repeat (4) tick(1, 4'b0000);
                repeat ($urandom_range(0, 7)) tick(1, 4'b0000);
                for (int j = 0; j < 2; j++) begin
                    logic [3:0] kill;
                    kill = 4'b0000;
                    kill[(wv + j) % 4] = 1'b1;
                    tick(1, kill);
                    d = -1;
                    for (int c = 1; c <= 30; c++) begin
                        tick(1, kill);
                        if (spawn != 4'b0000 && d < 0) d = c;
                    end
                    check("jitter_in_range", int'(d >= R && d <= R + 7), 1);
                    if (d >= 0 && d < seen_min) seen_min = d;
                    if (d > seen_max) seen_max = d;
                    tick(1, 4'b0000);
                end
            end
            check("jitter_distinct", int'(seen_max > seen_min), 1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
